// File: rtl/mem_data_arbiter.sv
// Two-port round-robin arbiter in front of a single memory data port.
// One access is in flight at a time: IDLE grants, ACCESS strobes the memory,
// WAIT holds a read strobe for READ_LAT cycles and captures the returned data.
module mem_data_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writeData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] mem_readData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam logic [2:0] LAT = 3'(READ_LAT);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic              port_q, port_d;
    logic              last_q, last_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;

    logic              win;
    logic              gnt0_c, gnt1_c;
    logic              mem_read_c, mem_write_c;

    // Next-state, grant and memory-strobe decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        we_d        = we_q;
        port_d      = port_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        win         = 1'b0;
        gnt0_c      = 1'b0;
        gnt1_c      = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;

        case (state_q)
            IDLE: begin
                // rst_n gates the grant so no pulse leaks out while held in reset.
                if (rst_n && (req0 || req1)) begin
                    // Under contention the port that did not win last time wins.
                    win     = (req0 && req1) ? ~last_q : req1;
                    gnt0_c  = ~win;
                    gnt1_c  = win;
                    last_d  = win;
                    port_d  = win;
                    we_d    = win ? we1    : we0;
                    addr_d  = win ? addr1  : addr0;
                    wdata_d = win ? wdata1 : wdata0;
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                if (we_q) begin
                    mem_write_c = 1'b1;
                    state_d     = IDLE;
                end else begin
                    mem_read_c = 1'b1;
                    cnt_d      = LAT;
                    state_d    = WAIT;
                end
            end

            WAIT: begin
                mem_read_c = 1'b1;
                if (cnt_q == 3'd1) begin
                    if (port_q) begin
                        rdata1_d  = mem_readData;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = mem_readData;
                        rvalid0_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, aborting any access.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before the edge, independent of statement order.
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            port_q    <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            port_q    <= port_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign gnt0      = gnt0_c;
    assign gnt1      = gnt1_c;
    assign MemRead   = mem_read_c;
    assign MemWrite  = mem_write_c;
    assign busy      = (state_q != IDLE);
    assign address   = addr_q;
    assign writeData = wdata_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Scoreboard bench for mem_data_arbiter: directed stimulus pushes expected
// grants, writes and read returns; a negedge monitor pops and compares them.
module tb_mem_data_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy, MemRead, MemWrite;
    logic [31:0] rdata0, rdata1, address, writeData, mem_readData;

    // Second instance with READ_LAT=3, data return driven directly by the bench.
    logic        d3_req0;
    logic        d3_we0;
    logic [31:0] d3_addr0;
    logic        d3_gnt0, d3_gnt1, d3_rvalid0, d3_rvalid1, d3_busy, d3_mr, d3_mw;
    logic [31:0] d3_rdata0, d3_rdata1, d3_address, d3_wd, d3_rd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rv_t;

    logic gnt_q[$];
    wr_t  wr_q[$];
    rv_t  rv_q[$];

    logic [31:0] mem [16];

    mem_data_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .address(address), .writeData(writeData),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_readData(mem_readData)
    );

    mem_data_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0(d3_req0), .req1(1'b0), .we0(d3_we0), .we1(1'b0),
        .addr0(d3_addr0), .addr1(32'd0), .wdata0(32'd0), .wdata1(32'd0),
        .gnt0(d3_gnt0), .gnt1(d3_gnt1), .rvalid0(d3_rvalid0), .rvalid1(d3_rvalid1),
        .rdata0(d3_rdata0), .rdata1(d3_rdata1), .busy(d3_busy),
        .address(d3_address), .writeData(d3_wd),
        .MemRead(d3_mr), .MemWrite(d3_mw), .mem_readData(d3_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model behind the READ_LAT=1 instance.
    assign mem_readData = mem[address[3:0]];
    always @(posedge clk) if (MemWrite) mem[address[3:0]] <= writeData;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant, write or read return.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt0 || gnt1) begin
                check("gnt_onehot", {63'd0, gnt0 & gnt1}, 64'd0);
                if (gnt_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL gnt_unexpected: got gnt0=%0b gnt1=%0b expected none", gnt0, gnt1);
                end else begin
                    logic ep;
                    ep = gnt_q.pop_front();
                    check("gnt_port", {63'd0, gnt1}, {63'd0, ep});
                end
            end
            if (MemRead || MemWrite)
                check("strobe_excl", {63'd0, MemRead & MemWrite}, 64'd0);
            if (MemWrite) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL write_unexpected: got addr %0h expected none", address);
                end else begin
                    wr_t ew;
                    ew = wr_q.pop_front();
                    check("write_addr", {32'd0, address}, {32'd0, ew.addr});
                    check("write_data", {32'd0, writeData}, {32'd0, ew.data});
                end
            end
            if (rvalid0 || rvalid1) begin
                if (rv_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rvalid_unexpected: got rvalid0=%0b rvalid1=%0b expected none", rvalid0, rvalid1);
                end else begin
                    rv_t er;
                    er = rv_q.pop_front();
                    check("rvalid_onehot", {63'd0, rvalid0 & rvalid1}, 64'd0);
                    check("rvalid_port", {63'd0, rvalid1}, {63'd0, er.port});
                    check("rdata", {32'd0, rvalid1 ? rdata1 : rdata0}, {32'd0, er.data});
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt0"},     {63'd0, gnt0}, 64'd0);
        check({tag, "_gnt1"},     {63'd0, gnt1}, 64'd0);
        check({tag, "_busy"},     {63'd0, busy}, 64'd0);
        check({tag, "_memread"},  {63'd0, MemRead}, 64'd0);
        check({tag, "_memwrite"}, {63'd0, MemWrite}, 64'd0);
        check({tag, "_rvalid0"},  {63'd0, rvalid0}, 64'd0);
        check({tag, "_rvalid1"},  {63'd0, rvalid1}, 64'd0);
        check({tag, "_address"},  {32'd0, address}, 64'd0);
        check({tag, "_wdata"},    {32'd0, writeData}, 64'd0);
        check({tag, "_rdata0"},   {32'd0, rdata0}, 64'd0);
        check({tag, "_rdata1"},   {32'd0, rdata1}, 64'd0);
    endtask

    // READ_LAT=3 expectations per cycle after the grant (k = 1..6).
    logic exp_mr [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_rv [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        d3_req0 = 0; d3_we0 = 0; d3_addr0 = 0; d3_rd = 0;

        // Reset: outputs zero even with a request pending.
        repeat (2) @(posedge clk);
        #1 req0 = 1'b1; we0 = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        req0 = 1'b0; we0 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Port 0 write addr 9 data 74.
        tick();
        req0 = 1; we0 = 1; addr0 = 32'd9; wdata0 = 32'd74;
        gnt_q.push_back(1'b0);
        wr_q.push_back('{addr: 32'd9, data: 32'd74});
        tick();
        req0 = 0;
        @(negedge clk);
        check("w_memwrite", {63'd0, MemWrite}, 64'd1);
        check("w_busy", {63'd0, busy}, 64'd1);
        tick();
        @(negedge clk);
        check("w_busy_done", {63'd0, busy}, 64'd0);
        check("w_memwrite_done", {63'd0, MemWrite}, 64'd0);

        // Port 1 read addr 9 returns 74, rdata0 untouched.
        tick();
        req1 = 1; we1 = 0; addr1 = 32'd9;
        gnt_q.push_back(1'b1);
        rv_q.push_back('{port: 1'b1, data: 32'd74});
        tick();
        req1 = 0;
        @(negedge clk);
        check("r_memread_access", {63'd0, MemRead}, 64'd1);
        tick();
        @(negedge clk);
        check("r_memread_wait", {63'd0, MemRead}, 64'd1);
        check("r_addr_wait", {32'd0, address}, 64'd9);
        tick();
        @(negedge clk);
        check("r_memread_off", {63'd0, MemRead}, 64'd0);
        check("r_rvalid1", {63'd0, rvalid1}, 64'd1);
        check("r_rdata0_kept", {32'd0, rdata0}, 64'd0);
        check("r_busy_done", {63'd0, busy}, 64'd0);

        // Contention with writes: grants alternate 0,1,0,1.
        tick();
        req0 = 1; we0 = 1; addr0 = 32'd1; wdata0 = 32'h11;
        req1 = 1; we1 = 1; addr1 = 32'd2; wdata1 = 32'h22;
        for (int i = 0; i < 2; i++) begin
            gnt_q.push_back(1'b0);
            gnt_q.push_back(1'b1);
            wr_q.push_back('{addr: 32'd1, data: 32'h11});
            wr_q.push_back('{addr: 32'd2, data: 32'h22});
        end
        repeat (7) tick();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;

        // Port 0 read; req1 raised during WAIT is granted only after rvalid0.
        tick();
        req0 = 1; we0 = 0; addr0 = 32'd1;
        gnt_q.push_back(1'b0);
        rv_q.push_back('{port: 1'b0, data: 32'h11});
        tick();
        req0 = 0;
        tick();
        req1 = 1; we1 = 1; addr1 = 32'd3; wdata1 = 32'h33;
        gnt_q.push_back(1'b1);
        wr_q.push_back('{addr: 32'd3, data: 32'h33});
        @(negedge clk);
        check("wait_no_gnt1", {63'd0, gnt1}, 64'd0);
        check("wait_memread", {63'd0, MemRead}, 64'd1);
        tick();
        @(negedge clk);
        check("after_rvalid_gnt1", {63'd0, gnt1}, 64'd1);
        check("after_rvalid_rvalid0", {63'd0, rvalid0}, 64'd1);
        tick();
        req1 = 0; we1 = 0;
        @(negedge clk);
        check("bb_memwrite", {63'd0, MemWrite}, 64'd1);

        // Reset in WAIT of a port 1 read: aborted, then first-edge acceptance.
        tick();
        req1 = 1; we1 = 0; addr1 = 32'd3;
        gnt_q.push_back(1'b1);
        tick();
        req1 = 0;
        tick();
        #1 rst_n = 1'b0;
        req0 = 1; we0 = 1; addr0 = 32'd5; wdata0 = 32'h55;
        #1;
        check_all_zero("abort");
        @(posedge clk);
        #2 rst_n = 1'b1;
        gnt_q.push_back(1'b0);
        wr_q.push_back('{addr: 32'd5, data: 32'h55});
        @(negedge clk);
        check("post_reset_gnt0", {63'd0, gnt0}, 64'd1);
        tick();
        req0 = 0; we0 = 0;
        @(negedge clk);
        check("post_reset_memwrite", {63'd0, MemWrite}, 64'd1);
        tick();
        @(negedge clk);
        check("post_reset_rvalid1", {63'd0, rvalid1}, 64'd0);
        check("post_reset_busy", {63'd0, busy}, 64'd0);

        // READ_LAT=3 read of addr 7; data is what mem_readData shows in the last WAIT cycle.
        tick();
        d3_req0 = 1; d3_we0 = 0; d3_addr0 = 32'd7; d3_rd = 32'hA0;
        @(negedge clk);
        check("l3_gnt0", {63'd0, d3_gnt0}, 64'd1);
        check("l3_memread_idle", {63'd0, d3_mr}, 64'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            d3_req0 = 1'b0;
            d3_rd = 32'hA0 + 32'(k);
            @(negedge clk);
            check($sformatf("l3_memread_c%0d", k), {63'd0, d3_mr}, {63'd0, exp_mr[k-1]});
            check($sformatf("l3_rvalid_c%0d", k), {63'd0, d3_rvalid0}, {63'd0, exp_rv[k-1]});
            if (k <= 4) check($sformatf("l3_addr_c%0d", k), {32'd0, d3_address}, 64'd7);
            if (k == 5) check("l3_rdata0", {32'd0, d3_rdata0}, 64'hA4);
        end
        check("l3_rdata1_kept", {32'd0, d3_rdata1}, 64'd0);

        tick();
        check("gnt_queue_empty", 64'(gnt_q.size()), 64'd0);
        check("wr_queue_empty", 64'(wr_q.size()), 64'd0);
        check("rv_queue_empty", 64'(rv_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
